// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures a slow, asynchronous clock (typically a divider output) in the system clock
//   domain. Gives one rise pulse per detected rising edge and reports the period and the
//   high time in system-clock cycles through a valid/ready result port. A missing rising
//   edge for TIMEOUT cycles is reported as a stall.
//
// Ports
//   clk_i         system clock, all logic on posedge
//   rst_ni        asynchronous active-low reset
//   clk_in_i      clock under measurement, asynchronous to clk_i
//   rise_pulse_o  one clk_i cycle high per detected clk_in_i rising edge
//   meas_valid_o  period_o/high_time_o hold an unconsumed measurement
//   meas_ready_i  consumer takes the result on an edge where meas_valid_o=1
//   period_o      cycles between the last two detected rising edges
//   high_time_o   cycles clk_in_i was high within that period
//   overrun_o     sticky: a result was overwritten before it was accepted
//   stalled_o     no rising edge for TIMEOUT cycles; cleared by the next rising edge
module clk_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clk_in_i,
  output logic             rise_pulse_o,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_time_o,
  output logic             overrun_o,
  output logic             stalled_o
);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  localparam logic [WIDTH-1:0] TimeoutVal = WIDTH'(TIMEOUT);
  // A TIMEOUT that does not fit in the counter must never fire.
  localparam bit TimeoutOk = (WIDTH >= 32) || ((TIMEOUT >> WIDTH) == 0);

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] hi_lat_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_time_q;
  logic             valid_q;
  logic             overrun_q;
  logic             stalled_q;

  logic             rise;
  logic             fall;
  logic             transfer;
  logic             timeout_hit;
  logic [WIDTH-1:0] cnt_inc;

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign transfer    = valid_q & meas_ready_i;
  assign timeout_hit = TimeoutOk && (cnt_q == TimeoutVal);
  // Saturating increment: a saturated count is reported as all-ones.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      s1_q <= clk_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;

      // A capture below overrides this, keeping valid high for the new result.
      if (transfer) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rise) begin
            // Reference edge only: no result yet.
            cnt_q     <= WIDTH'(1);
            hi_lat_q  <= '0;
            stalled_q <= 1'b0;
            state_q   <= StMeasure;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_q    <= cnt_q;
            high_time_q <= hi_lat_q;
            valid_q     <= 1'b1;
            if (valid_q && !meas_ready_i) begin
              overrun_q <= 1'b1;
            end
            cnt_q     <= WIDTH'(1);
            stalled_q <= 1'b0;
          end else if (timeout_hit) begin
            cnt_q     <= '0;
            stalled_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
          if (fall) begin
            hi_lat_q <= cnt_q;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rise_pulse_o = rise;
  assign meas_valid_o = valid_q;
  assign period_o     = period_q;
  assign high_time_o  = high_time_q;
  assign overrun_o    = overrun_q;
  assign stalled_o    = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter. clk_in is driven synchronously (between clk edges) so the
// synchronizer delay is deterministic; the reference model works on timestamps of the
// sampled input edges rather than on counters.
module tb_clk_period_meter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_in;
  logic             rise_pulse;
  logic             meas_valid;
  logic             meas_ready;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             overrun;
  logic             stalled;

  always #5 clk = ~clk;

  clk_period_meter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clk_in_i    (clk_in),
    .rise_pulse_o(rise_pulse),
    .meas_valid_o(meas_valid),
    .meas_ready_i(meas_ready),
    .period_o    (period),
    .high_time_o (high_time),
    .overrun_o   (overrun),
    .stalled_o   (stalled)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit    samp[$];      // clk_in value sampled at each clk edge since reset release
  bit    have_ref;
  int    last_rise;    // edge index at which the last rise was acted on
  int    m_hi;
  int    m_period;
  int    m_high;
  bit    m_valid;
  bit    m_overrun;
  bit    m_stalled;
  bit    m_rise;

  function automatic bit xs(input int i);
    return (i < 0) ? 1'b0 : samp[i];
  endfunction

  task automatic model_reset();
    samp.delete();
    have_ref  = 0;
    last_rise = 0;
    m_hi      = 0;
    m_period  = 0;
    m_high    = 0;
    m_valid   = 0;
    m_overrun = 0;
    m_stalled = 0;
    m_rise    = 0;
  endtask

  // Effect of one clk edge; an input edge sampled at edge k is acted on at edge k+2.
  task automatic model_edge(input bit v, input bit rdy);
    int n;
    bit r, f, xfer;
    int age;
    n    = samp.size();
    r    = xs(n - 2) & ~xs(n - 3);
    f    = ~xs(n - 2) & xs(n - 3);
    age  = have_ref ? (n - last_rise) : 0;
    xfer = m_valid & rdy;
    if (r) begin
      if (have_ref) begin
        if (m_valid && !rdy) m_overrun = 1;
        m_valid  = 1;
        m_period = age;
        m_high   = m_hi;
      end else if (xfer) begin
        m_valid = 0;
      end
      have_ref  = 1;
      last_rise = n;
      m_hi      = 0;
      m_stalled = 0;
    end else begin
      if (xfer) m_valid = 0;
      if (have_ref && f) m_hi = age;
      if (have_ref && age == int'(TIMEOUT)) begin
        have_ref  = 0;
        m_stalled = 1;
      end
    end
    samp.push_back(v);
    m_rise = xs(n - 1) & ~xs(n - 2);
  endtask

  task automatic compare_all();
    check("rise_pulse", 64'(rise_pulse), 64'(m_rise));
    check("meas_valid", 64'(meas_valid), 64'(m_valid));
    check("period", 64'(period), 64'(m_period));
    check("high_time", 64'(high_time), 64'(m_high));
    check("overrun", 64'(overrun), 64'(m_overrun));
    check("stalled", 64'(stalled), 64'(m_stalled));
  endtask

  // One clk cycle: drive between edges, advance the model, sample 1 time unit later.
  task automatic step(input bit v, input bit rdy);
    clk_in     = v;
    meas_ready = rdy;
    @(posedge clk);
    model_edge(v, rdy);
    #1;
    compare_all();
  endtask

  // mode: 0 ready low, 1 ready high, 2 random ready
  function automatic bit pick_ready(input int mode);
    if (mode == 2) return ($urandom_range(3, 0) != 0);
    return (mode == 1);
  endfunction

  task automatic wave(input int hi, input int lo, input int periods, input int mode);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, pick_ready(mode));
      for (int i = 0; i < lo; i++) step(1'b0, pick_ready(mode));
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rise_pulse", 64'(rise_pulse), 64'd0);
    check("rst_meas_valid", 64'(meas_valid), 64'd0);
    check("rst_period", 64'(period), 64'd0);
    check("rst_high_time", 64'(high_time), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_stalled", 64'(stalled), 64'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n      = 1'b0;
    clk_in     = 1'b0;
    meas_ready = 1'b0;
    model_reset();
    #2;
    compare_all();
    #10;
    rst_n = 1'b1;

    // Steady 5/5 square wave, ready always high.
    wave(5, 5, 8, 1);
    // 3/7 duty with ready low across captures, then drain.
    wave(3, 7, 3, 0);
    wave(3, 7, 2, 1);
    // Reset in the middle of a high phase.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    pulse_reset();
    wave(5, 5, 4, 1);
    // Stall after steady period 10, then restart.
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1);
    wave(4, 6, 4, 1);
    // Period equal to TIMEOUT: rise wins over the timeout.
    wave(50, 50, 3, 1);
    // Back-to-back captures against random ready, including capture plus transfer.
    wave(2, 2, 12, 2);
    wave(1, 1, 10, 2);
    // Random waveform segments.
    for (int s = 0; s < 40; s++) begin
      int hi, lo;
      hi = int'($urandom_range(15, 1));
      lo = ($urandom_range(9, 0) == 0) ? int'($urandom_range(130, 90))
                                       : int'($urandom_range(15, 1));
      wave(hi, lo, int'($urandom_range(3, 1)), int'($urandom_range(2, 0)));
    end
    step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the slow clock produced by the design's clock divider, in the system clock domain. Synchronizes the divided clock, emits a one-cycle pulse per rising edge, and reports period and high time in system-clock cycles through a valid/ready result port. Used to check divider output on hardware and to give downstream logic a single-cycle enable in place of a derived clock. Detects a stopped input clock and reports it.

## Interface
- WIDTH, 32, width of the cycle counter and the result fields
- TIMEOUT, 50_000_000, cycles without a rising edge before the input is declared stalled; must be < 2^WIDTH-1
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other clock domain
- clk_in  in  1  divided clock to measure; asynchronous to clk
- rise_pulse  out  1  high for exactly one clk cycle per detected clk_in rising edge
- meas_valid  out  1  result fields hold an unconsumed measurement
- meas_ready  in  1  consumer accepts the result on a clk edge where meas_valid=1
- period  out  WIDTH  clk cycles between the last two detected rising edges
- high_time  out  WIDTH  clk cycles clk_in was high within that period
- overrun  out  1  sticky; a result was overwritten before it was accepted
- stalled  out  1  no rising edge for TIMEOUT cycles; cleared at next rising edge

## Operation
- Sync: s1 <= clk_in, s2 <= s1, s3 <= s2; all reset to 0. rise = s2 & ~s3; fall = ~s2 & s3. rise_pulse = rise.
- Counter cnt (WIDTH bits): increments by 1 each cycle, saturates at all-ones, never wraps.
- States: IDLE (no reference edge yet), MEASURE.
- IDLE: cnt held at 0. On rise: cnt <= 1, hi_lat <= 0, go MEASURE, no result produced.
- MEASURE, rise: period <= cnt, high_time <= hi_lat, meas_valid <= 1, cnt <= 1, stalled <= 0.
- MEASURE, fall: hi_lat <= cnt; cnt keeps counting.
- MEASURE, no rise and cnt == TIMEOUT: go IDLE, stalled <= 1, cnt <= 0, no result produced.
- Rise and cnt == TIMEOUT in the same cycle: rise wins, result captured, stays MEASURE.
- Rise seen in IDLE also clears stalled.
- Handshake: transfer = meas_valid & meas_ready at a clk edge. Transfer without capture: meas_valid <= 0. Capture with transfer on the same edge: new values loaded, meas_valid stays 1, no overrun. Capture while meas_valid=1 and meas_ready=0: values overwritten, overrun <= 1.
- overrun clears only on reset.
- period/high_time hold their values while meas_valid=0. They change only on capture.

## Timing
- Reset (async assert): state IDLE, s1..s3=0, cnt=0, hi_lat=0, period=0, high_time=0, meas_valid=0, overrun=0, stalled=0, rise_pulse=0. Reset mid-measurement discards the partial count. The first rise after release is a reference edge only.
- Edge latency: clk_in first sampled high at edge E0 -> s2=1 after E1 -> rise_pulse high between E1 and E2 -> result registered and meas_valid=1 after E2.
- Period accuracy: rises detected at cycles t and t+P give period=P. Synchronizer jitter is ±1 cycle per edge on an asynchronous input.
- Minimum measurable period: 2 cycles (1 high, 1 low). Faster input is undefined.
- Saturated cnt is reported as all-ones and does not fire TIMEOUT if TIMEOUT is out of range (parameter rule forbids this).
- meas_ready may be held high permanently. meas_valid then pulses one cycle per capture.

## Test plan
- clk_in square wave, 5 high / 5 low, meas_ready=1, from reset -> first rise gives rise_pulse only, meas_valid=0; every later rise gives period=10, high_time=5, meas_valid pulse of 1 cycle; overrun=0.
- Duty 3 high / 7 low, meas_ready=0 across two captures -> meas_valid stays 1, period=10, high_time=3 from the latest capture, overrun=1. Then raise meas_ready -> meas_valid drops after one edge and overrun stays 1.
- TIMEOUT=100, clk_in stops low after steady period 10 -> stalled=1 exactly 100 cycles after last rise_pulse, no result. Restart -> stalled=0 at first rise, first valid result at second rise.
- Rise coinciding with cnt==TIMEOUT (period 100, TIMEOUT=100) -> period=100 captured, stalled stays 0.
- rst_n pulsed low mid-period -> all outputs 0 immediately (async). The next rise produces no result; the following rise reports the full period.
- Capture and meas_ready=1 on the same edge while meas_valid=1 -> new values visible, meas_valid stays 1, overrun=0.
